// File: rtl/reader.sv
// ---------------------------------------------------------------------------
// reader
// Receiving end of a one-way strobe interface. A byte on q is captured on the
// first cycle of every high run of sync, buffered in a small FIFO and handed
// downstream over a valid/ready handshake. The sender cannot be stalled, so a
// byte arriving while the FIFO is full is dropped and flagged. A strobe that
// stays high for more than one cycle is flagged as a protocol error.
//
// Parameters:
//   DEPTH      FIFO entries (power of 2, >= 2)
//   AW         pointer width, log2(DEPTH)
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   q          sender data, meaningful while sync=1
//   sync       capture strobe
//   dout       FIFO head byte, 8'h00 when empty
//   valid      FIFO non-empty
//   ready      consumer takes dout when valid && ready at the edge
//   level      FIFO occupancy, 0..DEPTH
//   overflow   sticky: a byte was dropped on a full FIFO
//   proto_err  sticky: sync was high on two or more consecutive cycles
//   drop_cnt   saturating count of dropped bytes (only with READER_DROPCNT_EN)
//
// Optional feature macro: READER_DROPCNT_EN
// ---------------------------------------------------------------------------
module reader #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [7:0]    q,
    input  logic          sync,
    output logic [7:0]    dout,
    output logic          valid,
    input  logic          ready,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          proto_err
`ifdef READER_DROPCNT_EN
    ,
    output logic [7:0]    drop_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CAPT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_proto_err;
    logic        r_overflow;
    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_push_ok;
    logic        w_drop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // Only the first cycle of a sync high run captures.
    assign w_push    = (r_state == S_IDLE) && sync;
    assign w_pop     = !w_empty && ready;

    // A simultaneous pop frees the slot the push lands in, so nothing is lost.
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && w_full && !w_pop;

    assign valid     = !w_empty;
    assign dout      = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
    assign level     = r_wr_ptr - r_rd_ptr;
    assign overflow  = r_overflow;
    assign proto_err = r_proto_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_proto_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (sync) r_state <= S_CAPT;
                end
                S_CAPT: begin
                    if (sync) begin
                        r_state     <= S_HOLD;
                        r_proto_err <= 1'b1;
                    end else begin
                        r_state     <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (!sync) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_drop)    r_overflow <= 1'b1;
        end
    end

    // Storage needs no reset; entries are only visible once written.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= q;
    end

`ifdef READER_DROPCNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_cnt <= 8'h00;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'h01;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_reader.sv
// ---------------------------------------------------------------------------
// tb_reader
// Directed self-checking bench for reader. Each task drives one scenario and
// compares the DUT outputs against hand-computed values; the stress task uses
// a queue model of the FIFO. Inputs change and outputs are sampled 1 ns after
// each rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reader;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk;
    logic          reset_n;
    logic [7:0]    q;
    logic          sync;
    logic [7:0]    dout;
    logic          valid;
    logic          ready;
    logic [AW:0]   level;
    logic          overflow;
    logic          proto_err;
`ifdef READER_DROPCNT_EN
    logic [7:0]    drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    reader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .q         (q),
        .sync      (sync),
        .dout      (dout),
        .valid     (valid),
        .ready     (ready),
        .level     (level),
        .overflow  (overflow),
        .proto_err (proto_err)
`ifdef READER_DROPCNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] data);
        sync = 1'b1;
        q    = data;
        tick();
        sync = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        sync    = 1'b0;
        ready   = 1'b0;
        q       = 8'h00;
        #3;
        tick();
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (dout !== 8'h00) begin errors++; $display("[TB] FAIL reset_dout: got %h expected 00", dout); end
        checks++; if (level !== 4'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_proto_err: got %b expected 0", proto_err); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_pre_valid[%0d]: got %b expected 0", i, valid); end
            sync = 1'b1;
            q    = vals[i];
            tick();
            sync = 1'b0;
            checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid[%0d]: got %b expected 1", i, valid); end
            checks++; if (dout !== vals[i]) begin errors++; $display("[TB] FAIL basic_dout[%0d]: got %h expected %h", i, dout, vals[i]); end
            checks++; if (level !== 4'd1) begin errors++; $display("[TB] FAIL basic_level[%0d]: got %0d expected 1", i, level); end
            tick();
            checks++; if (level !== 4'd0) begin errors++; $display("[TB] FAIL basic_drain[%0d]: got %0d expected 0", i, level); end
            tick();
        end
        checks++; if (overflow !== 1'b0 || proto_err !== 1'b0) begin errors++; $display("[TB] FAIL basic_flags: got %b%b expected 00", overflow, proto_err); end
    endtask

    task automatic test_overflow();
        ready = 1'b0;
        for (int i = 1; i <= 10; i++) pulse(8'(i));
        checks++; if (level !== 4'd8) begin errors++; $display("[TB] FAIL ovf_level: got %0d expected 8", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflow); end
`ifdef READER_DROPCNT_EN
        checks++; if (drop_cnt !== 8'd2) begin errors++; $display("[TB] FAIL ovf_drop_cnt: got %0d expected 2", drop_cnt); end
`endif
        ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks++; if (dout !== 8'(i)) begin errors++; $display("[TB] FAIL ovf_order[%0d]: got %h expected %h", i, dout, 8'(i)); end
            tick();
        end
        checks++; if (valid !== 1'b0 || level !== 4'd0) begin errors++; $display("[TB] FAIL ovf_empty: got valid=%b level=%0d expected valid=0 level=0", valid, level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp [8];
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 8; i++) pulse(8'hB0 + 8'(i));
        checks++; if (level !== 4'd8) begin errors++; $display("[TB] FAIL fpp_fill: got %0d expected 8", level); end
        sync  = 1'b1;
        q     = 8'hAA;
        ready = 1'b1;
        tick();
        sync  = 1'b0;
        checks++; if (level !== 4'd8) begin errors++; $display("[TB] FAIL fpp_level: got %0d expected 8", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL fpp_overflow: got %b expected 0", overflow); end
`ifdef READER_DROPCNT_EN
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL fpp_drop_cnt: got %0d expected 0", drop_cnt); end
`endif
        for (int i = 0; i < 7; i++) exp[i] = 8'hB1 + 8'(i);
        exp[7] = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            checks++; if (dout !== exp[i]) begin errors++; $display("[TB] FAIL fpp_order[%0d]: got %h expected %h", i, dout, exp[i]); end
            tick();
        end
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL fpp_empty: got %b expected 0", valid); end
    endtask

    task automatic test_long_sync();
        logic [7:0] seq [4];
        seq[0] = 8'h5A; seq[1] = 8'h5B; seq[2] = 8'h5C; seq[3] = 8'h5D;
        ready = 1'b0;
        sync  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            q = seq[i];
            tick();
            checks++; if (level !== 4'd1) begin errors++; $display("[TB] FAIL long_level[%0d]: got %0d expected 1", i, level); end
            checks++; if (proto_err !== (i != 0)) begin errors++; $display("[TB] FAIL long_proto[%0d]: got %b expected %b", i, proto_err, (i != 0)); end
        end
        sync = 1'b0;
        tick();
        pulse(8'h66);
        checks++; if (level !== 4'd2) begin errors++; $display("[TB] FAIL long_next_level: got %0d expected 2", level); end
        ready = 1'b1;
        checks++; if (dout !== 8'h5A) begin errors++; $display("[TB] FAIL long_first: got %h expected 5A", dout); end
        tick();
        checks++; if (dout !== 8'h66) begin errors++; $display("[TB] FAIL long_second: got %h expected 66", dout); end
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL long_empty: got %b expected 0", valid); end
        checks++; if (proto_err !== 1'b1 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL long_flags: got %b%b expected 10", proto_err, overflow); end
    endtask

    task automatic test_async_reset();
        ready = 1'b0;
        pulse(8'h01);
        pulse(8'h02);
        pulse(8'h03);
        checks++; if (level !== 4'd3) begin errors++; $display("[TB] FAIL areset_pre_level: got %0d expected 3", level); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_valid: got %b expected 0", valid); end
        checks++; if (level !== 4'd0) begin errors++; $display("[TB] FAIL areset_level: got %0d expected 0", level); end
        checks++; if (dout !== 8'h00) begin errors++; $display("[TB] FAIL areset_dout: got %h expected 00", dout); end
        checks++; if (proto_err !== 1'b0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL areset_flags: got %b%b expected 00", proto_err, overflow); end
        tick();
        reset_n = 1'b1;
        tick();
        pulse(8'h77);
        checks++; if (dout !== 8'h77 || level !== 4'd1) begin errors++; $display("[TB] FAIL areset_after: got dout=%h level=%0d expected dout=77 level=1", dout, level); end
        ready = 1'b1;
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_drain: got %b expected 0", valid); end
    endtask

    task automatic test_stress();
        logic [7:0] sb [$];
        int         sent;
        int         popped;
        int         accepted;
        int         cycles;
        bit         phase;
        bit         exp_ovf;
        bit         exp_valid;
        logic [7:0] exp_dout;
        bit         m_pop;
        bit         m_push;
        int         pre;

        do_reset();
        sent = 0; popped = 0; accepted = 0; cycles = 0;
        phase = 1'b0; exp_ovf = 1'b0;
        while ((sent < 1000 || sb.size() != 0) && cycles < 20000) begin
            if (sent < 1000 && !phase) begin
                sync = 1'b1;
                q    = 8'($urandom);
                sent++;
            end else begin
                sync = 1'b0;
            end
            phase = !phase;
            ready = (sent >= 1000) ? 1'b1 : ($urandom_range(0, 3) != 0);

            exp_valid = (sb.size() != 0);
            exp_dout  = exp_valid ? sb[0] : 8'h00;
            checks++; if (valid !== exp_valid) begin errors++; $display("[TB] FAIL stress_valid@%0d: got %b expected %b", cycles, valid, exp_valid); end
            checks++; if (dout !== exp_dout) begin errors++; $display("[TB] FAIL stress_dout@%0d: got %h expected %h", cycles, dout, exp_dout); end
            checks++; if (level !== 4'(sb.size())) begin errors++; $display("[TB] FAIL stress_level@%0d: got %0d expected %0d", cycles, level, sb.size()); end
            checks++; if (overflow !== exp_ovf) begin errors++; $display("[TB] FAIL stress_overflow@%0d: got %b expected %b", cycles, overflow, exp_ovf); end

            m_pop  = exp_valid && ready;
            m_push = sync;
            pre    = sb.size();
            if (m_push) begin
                if (pre < DEPTH || m_pop) begin
                    sb.push_back(q);
                    accepted++;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
            tick();
            if (m_pop) begin
                void'(sb.pop_front());
                popped++;
            end
            cycles++;
        end
        sync = 1'b0;
        checks++; if (cycles >= 20000) begin errors++; $display("[TB] FAIL stress_timeout: got %0d cycles expected < 20000", cycles); end
        checks++; if (popped !== accepted) begin errors++; $display("[TB] FAIL stress_count: got %0d popped expected %0d", popped, accepted); end
        checks++; if (valid !== 1'b0 || level !== 4'd0) begin errors++; $display("[TB] FAIL stress_final: got valid=%b level=%0d expected valid=0 level=0", valid, level); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL stress_proto: got %b expected 0", proto_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_long_sync();
        test_async_reset();
        test_stress();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reader.md
Name: reader

Overview:
- Receiving end of the one-way strobe interface.
- Samples an 8-bit data bus on every single-cycle `sync` pulse and stores the bytes in a small FIFO.
- Delivers the bytes downstream over a valid/ready handshake.
- There is no back-pressure toward the sender. Bytes that arrive while the FIFO is full are dropped and flagged, and malformed strobes are detected.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- AW, 3, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- q  input  8  data from the sender; valid only while sync=1.
- sync  input  1  capture strobe; nominally a 1-cycle pulse, with at least 1 low cycle between pulses.
- dout  output  8  FIFO head byte; 8'h00 when empty.
- valid  output  1  FIFO non-empty.
- ready  input  1  consumer accepts dout when valid&&ready at the clock edge.
- level  output  AW+1  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky; a byte was dropped because the FIFO was full.
- proto_err  output  1  sticky; sync was high for 2 or more consecutive cycles.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Pointers and level go to 0.
  - valid=0, dout=8'h00, overflow=0, proto_err=0.
  - Strobe FSM goes to S_IDLE.
  - FIFO storage contents are don't-care.
- Reset applied mid-transfer discards all stored bytes. The first sync after reset_n rises is captured normally.

Strobe FSM (registered state):
- S_IDLE: when sync=1, capture q and go to S_CAPT; otherwise stay.
- S_CAPT: when sync=0, go to S_IDLE. When sync=1:
  - set proto_err;
  - do NOT capture again;
  - go to S_HOLD.
- S_HOLD: stay while sync=1 (no captures); go to S_IDLE when sync=0.
- Any unused encoding goes to S_IDLE.
- Consequence: each contiguous high run of sync yields exactly one capture, taken on its first cycle.

Capture and push:
- push = (state==S_IDLE) && sync.
- Data is written at the same edge that samples sync.
- Capture-to-valid latency is 1 cycle: valid rises after the capturing edge.

Pop:
- pop = valid && ready.
- The read pointer advances at the edge.
- dout is driven combinationally from the head entry; it updates the cycle after a pop.

Full and empty rules:
- push && full && !pop: byte dropped, level unchanged, overflow set.
- push && full && pop: both happen; level stays DEPTH, no drop.
- push && empty: stored normally. Bypass to dout in the same cycle is NOT allowed.
- pop while empty: impossible, because valid=0.

Level:
- level = level + push_ok − pop, where push_ok is a push that is not dropped.
- level never exceeds DEPTH.

Pointers:
- AW+1 bits, wrap modulo 2*DEPTH.
- full when the MSBs differ and the low bits are equal.
- empty when the pointers are equal.

Sticky flags:
- overflow and proto_err clear only on reset.

Optional Feature:
- Macro: READER_DROPCNT_EN.
- Defined:
  - Adds output drop_cnt [7:0].
  - Increments on each dropped byte and saturates at 8'hFF.
  - Resets to 0.
- Undefined:
  - The port is absent and no counter logic exists.
  - overflow behaviour is identical in both builds.

Test Plan:
1. Reset, then sync pulses with q=8'h11, 8'h22, 8'h33 at 3-cycle spacing, ready=1 → valid high 1 cycle after each capture, dout sequence 11, 22, 33, level peaks at 1, no flags.
2. ready=0, 10 pulses with q=1..10, DEPTH=8 → level=8, overflow=1, drop_cnt=2 (if enabled). Raise ready → dout yields 1..8 in order; bytes 9 and 10 are lost.
3. FIFO full, sync pulse with q=8'hAA in the same cycle as a pop (ready=1) → no drop, level stays 8, overflow unchanged, AA is read last.
4. sync held high 4 cycles with q=8'h5A→8'h5B→8'h5C→8'h5D → exactly one entry (5A) is stored, proto_err=1 from the second cycle; the next clean pulse is captured normally.
5. Assert reset_n=0 asynchronously between edges with level=3 → valid, level and flags go to 0 immediately. After release, one pulse with q=8'h77 → dout=77, level=1.
6. Stress with pulses at minimum spacing (1 high, 1 low), ready toggling randomly, 1000 bytes → a scoreboard matches order exactly with no overflow while level < DEPTH. Includes multiple pointer wraps.
